// File: rtl/lc3b_types.sv
// Shared types and sizing constants for the LC-3b memory subsystem.
// Contents:
//   LINE_W, ADDR_W, SEL_W  cache-line, line-address and byte-select widths
//   mem_arb_state_t        state encoding of the I/D memory arbiter
package lc3b_types;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 12;
    localparam int SEL_W  = LINE_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } mem_arb_state_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant selection between the I-cache and D-cache ports.
// Build option: MEM_ARB_RR_EN selects round-robin on a tie; otherwise D wins.
// Ports:
//   i_pend, d_pend  requester pending (cyc & stb)
//   last            1 = D was served last, 0 = I was served last
//   gnt_i, gnt_d    one-hot (or zero) grant
module mem_arb_grant (
    input  logic i_pend,
    input  logic d_pend,
    input  logic last,
    output logic gnt_i,
    output logic gnt_d
);

`ifdef MEM_ARB_RR_EN
    // On a tie the port that was not served last wins.
    assign gnt_d = d_pend & (~i_pend | ~last);
    assign gnt_i = i_pend & (~d_pend |  last);
`else
    logic unused_last;
    assign unused_last = last;
    assign gnt_d = d_pend;
    assign gnt_i = i_pend & ~d_pend;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single line-wide memory.
// One transaction outstanding at a time; all outputs except *_rty registered.
// Build option: MEM_ARB_RR_EN enables round-robin tie-break (default: D wins).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_* / d_*                    cache-side bus (cyc/stb/we/adr/dat_m/sel in,
//                                dat_s/ack/rty out)
//   m_cyc/m_stb/m_we/m_adr/
//   m_wdata/m_sel                memory request (out)
//   m_rdata/m_ack/m_retry        memory response (in)
module mem_arbiter #(
    parameter int LINE_W = lc3b_types::LINE_W,
    parameter int ADDR_W = lc3b_types::ADDR_W,
    parameter int SEL_W  = lc3b_types::SEL_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_adr,
    input  logic [LINE_W-1:0] i_dat_m,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [LINE_W-1:0] i_dat_s,
    output logic              i_ack,
    output logic              i_rty,

    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [LINE_W-1:0] d_dat_m,
    input  logic [SEL_W-1:0]  d_sel,
    output logic [LINE_W-1:0] d_dat_s,
    output logic              d_ack,
    output logic              d_rty,

    output logic              m_cyc,
    output logic              m_stb,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_adr,
    output logic [LINE_W-1:0] m_wdata,
    output logic [SEL_W-1:0]  m_sel,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_ack,
    input  logic              m_retry
);
    import lc3b_types::*;

    mem_arb_state_t    state_q, state_d;
    logic              m_cyc_q, m_we_q;
    logic [ADDR_W-1:0] m_adr_q;
    logic [LINE_W-1:0] m_wdata_q;
    logic [SEL_W-1:0]  m_sel_q;
    logic [LINE_W-1:0] i_dat_s_q, d_dat_s_q;
    logic              i_ack_q, d_ack_q;

    logic i_pend, d_pend, gnt_i, gnt_d, last, m_adv;

    assign i_pend = i_cyc & i_stb;
    assign d_pend = d_cyc & d_stb;
    // Retry overrides an ack in the same cycle.
    assign m_adv  = m_ack & ~m_retry;

`ifdef MEM_ARB_RR_EN
    logic last_q;   // 1 = D served last
    assign last = last_q;
`else
    assign last = 1'b0;
`endif

    mem_arb_grant u_grant (
        .i_pend (i_pend),
        .d_pend (d_pend),
        .last   (last),
        .gnt_i  (gnt_i),
        .gnt_d  (gnt_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_d)      state_d = GRANT_D;
                     else if (gnt_i) state_d = GRANT_I;
            GRANT_I,
            GRANT_D: if (m_adv)      state_d = DONE;
            DONE:                    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_cyc_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_adr_q   <= '0;
            m_wdata_q <= '0;
            m_sel_q   <= '0;
            i_dat_s_q <= '0;
            d_dat_s_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (gnt_i | gnt_d) begin
                        m_cyc_q   <= 1'b1;
                        m_we_q    <= gnt_d ? d_we    : i_we;
                        m_adr_q   <= gnt_d ? d_adr   : i_adr;
                        m_wdata_q <= gnt_d ? d_dat_m : i_dat_m;
                        m_sel_q   <= gnt_d ? d_sel   : i_sel;
`ifdef MEM_ARB_RR_EN
                        last_q    <= gnt_d;
`endif
                    end
                end
                // Read data is only taken on reads so a port's dat_s keeps
                // the last line it actually read.
                GRANT_I: begin
                    if (m_adv) begin
                        m_cyc_q <= 1'b0;
                        i_ack_q <= 1'b1;
                        if (!m_we_q) i_dat_s_q <= m_rdata;
                    end
                end
                GRANT_D: begin
                    if (m_adv) begin
                        m_cyc_q <= 1'b0;
                        d_ack_q <= 1'b1;
                        if (!m_we_q) d_dat_s_q <= m_rdata;
                    end
                end
                DONE: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign m_cyc   = m_cyc_q;
    assign m_stb   = m_cyc_q;
    assign m_we    = m_we_q;
    assign m_adr   = m_adr_q;
    assign m_wdata = m_wdata_q;
    assign m_sel   = m_sel_q;
    assign i_dat_s = i_dat_s_q;
    assign d_dat_s = d_dat_s_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rty   = i_cyc & i_stb & ~i_ack_q;
    assign d_rty   = d_cyc & d_stb & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int LW = 128;
    localparam int AW = 12;
    localparam int SW = 16;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cyc, i_stb, i_we, d_cyc, d_stb, d_we;
    logic [AW-1:0] i_adr, d_adr;
    logic [LW-1:0] i_dat_m, d_dat_m, i_dat_s, d_dat_s;
    logic [SW-1:0] i_sel, d_sel;
    logic          i_ack, i_rty, d_ack, d_rty;
    logic          m_cyc, m_stb, m_we, m_ack, m_retry;
    logic [AW-1:0] m_adr;
    logic [LW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_sel;

    int checks = 0;
    int errors = 0;

    localparam logic [LW-1:0] RD1 = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    localparam logic [LW-1:0] WD2 = 128'hCAFEF00D_11112222_33334444_55556666;
    localparam logic [LW-1:0] RD5 = 128'h55555555_AAAAAAAA_0F0F0F0F_F0F0F0F0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr),
        .i_dat_m(i_dat_m), .i_sel(i_sel), .i_dat_s(i_dat_s),
        .i_ack(i_ack), .i_rty(i_rty),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr),
        .d_dat_m(d_dat_m), .d_sel(d_sel), .d_dat_s(d_dat_s),
        .d_ack(d_ack), .d_rty(d_rty),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_wdata(m_wdata), .m_sel(m_sel), .m_rdata(m_rdata),
        .m_ack(m_ack), .m_retry(m_retry)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_d;
        logic [AW-1:0] exp_a;
        rst = 1'b1;
        i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat_m = '0; i_sel = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat_m = '0; d_sel = '0;
        m_rdata = '0; m_ack = 0; m_retry = 0;
        nxt(); nxt();
        rst = 1'b0;
        chk("rst_m_cyc", m_cyc, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_adr", m_adr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_i_dat_s", i_dat_s, 0);
        chk("rst_d_dat_s", d_dat_s, 0);

        // Single I read, minimum latency
        i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 12'h0A3; i_sel = 16'hFFFF;
        #1 chk("t1_i_rty_req", i_rty, 1);
        nxt();
        chk("t1_m_cyc", m_cyc, 1);
        chk("t1_m_stb", m_stb, 1);
        chk("t1_m_adr", m_adr, 12'h0A3);
        chk("t1_m_we", m_we, 0);
        m_ack = 1; m_rdata = RD1;
        nxt();
        m_ack = 0;
        chk("t1_i_ack", i_ack, 1);
        chk("t1_i_dat_s", i_dat_s, RD1);
        chk("t1_d_ack", d_ack, 0);
        chk("t1_m_cyc_off", m_cyc, 0);
        chk("t1_i_rty_ack", i_rty, 0);
        i_cyc = 0; i_stb = 0;
        nxt();
        chk("t1_i_ack_once", i_ack, 0);
        // Stray ack while idle
        m_ack = 1;
        nxt();
        m_ack = 0;
        chk("stray_m_cyc", m_cyc, 0);
        chk("stray_i_ack", i_ack, 0);
        chk("stray_d_ack", d_ack, 0);

        // D write with 4 retry cycles (last one also carries ack)
        d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 12'h3FF; d_sel = 16'hFFFF; d_dat_m = WD2;
        nxt();
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("t2_m_cyc_c%0d", k), m_cyc, 1);
            chk($sformatf("t2_m_adr_c%0d", k), m_adr, 12'h3FF);
            chk($sformatf("t2_m_wdata_c%0d", k), m_wdata, WD2);
            chk($sformatf("t2_m_we_c%0d", k), m_we, 1);
            chk($sformatf("t2_m_sel_c%0d", k), m_sel, 16'hFFFF);
            chk($sformatf("t2_d_rty_c%0d", k), d_rty, 1);
            m_retry = (k <= 4);
            m_ack   = (k >= 4);
            nxt();
        end
        m_ack = 0; m_retry = 0;
        chk("t2_d_ack", d_ack, 1);
        chk("t2_i_ack", i_ack, 0);
        chk("t2_m_cyc_off", m_cyc, 0);
        chk("t2_d_rty_ack", d_rty, 0);
        chk("t2_d_dat_s_write", d_dat_s, 0);
        chk("t2_i_dat_s_kept", i_dat_s, RD1);
        d_cyc = 0; d_stb = 0; d_we = 0;
        nxt();
        chk("t2_d_ack_once", d_ack, 0);

        // Tie: both pending continuously
        rst = 1;
        nxt();
        rst = 0;
        chk("rst2_i_dat_s", i_dat_s, 0);
        i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 12'h111;
        d_cyc = 1; d_stb = 1; d_we = 0; d_adr = 12'h222;
        #1;
        for (int g = 0; g < 4; g++) begin
            exp_d = RR ? (g % 2 == 0) : 1'b1;
            exp_a = exp_d ? 12'h222 : 12'h111;
            chk($sformatf("tie%0d_idle_m_cyc", g), m_cyc, 0);
            nxt();
            chk($sformatf("tie%0d_m_adr", g), m_adr, exp_a);
            chk($sformatf("tie%0d_m_cyc", g), m_cyc, 1);
            m_ack = 1; m_rdata = 128'h1000 + 128'(g);
            nxt();
            m_ack = 0;
            chk($sformatf("tie%0d_d_ack", g), d_ack, exp_d);
            chk($sformatf("tie%0d_i_ack", g), i_ack, !exp_d);
            if (exp_d) chk($sformatf("tie%0d_d_dat_s", g), d_dat_s, 128'h1000 + 128'(g));
            else       chk($sformatf("tie%0d_i_dat_s", g), i_dat_s, 128'h1000 + 128'(g));
            if (!RR) chk($sformatf("tie%0d_i_rty", g), i_rty, 1);
            nxt();
        end
        i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0;
        nxt();

        // Reset on the second cycle of GRANT_I
        i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 12'h055;
        nxt();
        chk("t4_m_cyc_g1", m_cyc, 1);
        nxt();
        chk("t4_m_cyc_g2", m_cyc, 1);
        rst = 1; m_ack = 1; m_rdata = 128'hBAD;
        i_cyc = 0; i_stb = 0;
        nxt();
        rst = 0; m_ack = 0;
        chk("t4_m_cyc_after_rst", m_cyc, 0);
        chk("t4_i_ack_after_rst", i_ack, 0);
        chk("t4_i_dat_s_after_rst", i_dat_s, 0);
        nxt();
        chk("t4_i_ack_later", i_ack, 0);
        chk("t4_m_cyc_later", m_cyc, 0);

        // Later request with stb dropped after grant still completes
        i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 12'h066;
        nxt();
        chk("t5_m_cyc", m_cyc, 1);
        chk("t5_m_adr", m_adr, 12'h066);
        i_cyc = 0; i_stb = 0;
        #1 chk("t5_i_rty_drop", i_rty, 0);
        nxt();
        chk("t5_m_cyc_hold", m_cyc, 1);
        chk("t5_i_ack_early", i_ack, 0);
        m_ack = 1; m_rdata = RD5;
        nxt();
        m_ack = 0;
        chk("t5_i_ack", i_ack, 1);
        chk("t5_i_dat_s", i_dat_s, RD5);
        chk("t5_d_ack", d_ack, 0);
        nxt();
        chk("t5_i_ack_once", i_ack, 0);
        chk("t5_m_cyc_idle", m_cyc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
